rv32_decode_pipe: RTL
=====================

RV32_DECODE_PIPE -- requirements
Module: rv32_decode_pipe

Interface
REQ-001 Parameter M_EXT, default 0, SHALL enable decode of the RV32M instructions MUL through REMU when set to 1.
REQ-002 Parameter ILLEGAL_VALID, default 1, SHALL make an illegal instruction assert valid_out together with illegal_out when 1, and drop it as a bubble when 0.
REQ-003 Clock, reset and handshake ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  pc_in/instr_in valid
- stall_in  in  1  downstream hold
- flush_in  in  1  squash stage contents
REQ-004 Data input ports SHALL be:
- pc_in  in  32  instruction address
- instr_in  in  32  instruction word
- ex_load_in  in  1  execute stage holds a valid load
- ex_rd_in  in  5  destination of that load
REQ-005 Hazard and address output ports SHALL be:
- hazard_stall_out  out  1  combinational; freeze fetch
- rs1_addr_out, rs2_addr_out  out  5 each  combinational = instr_in[19:15] and instr_in[24:20], for the register file
REQ-006 Registered control outputs SHALL be:
- valid_out, illegal_out  1 each
- alu_op_out  4
- alu_sub_sra_out, alu_src1_out, alu_src2_out  1 each
REQ-007 Registered memory, branch and register-write outputs SHALL be:
- rd_write_out  1
- mem_read_out, mem_write_out  1 each
- mem_width_out  2 (0 byte, 1 half, 2 word)
- mem_unsigned_out  1
- branch_out, branch_negate_out, jal_out, jalr_out  1 each
REQ-008 Registered datapath outputs SHALL be:
- muldiv_out  1; muldiv_op_out  3 (= funct3)
- pc_out, imm_out  32 each
- rs1_out, rs2_out, rd_out  5 each

Function
REQ-009 Decode SHALL be a single registered stage with latency 1 cycle from an accepted instruction to valid_out.
REQ-010 Per-cycle priority SHALL be flush_in, then stall_in, then hazard, then load.
- flush_in=1: valid_out<=0, overriding stall_in.
- stall_in=1 (no flush): all registered outputs hold.
- Otherwise, hazard: valid_out<=0 (bubble).
- Otherwise: load the decode of valid_in/instr_in.
REQ-011 hazard_stall_out SHALL equal valid_in & ex_load_in & (ex_rd_in!=0) & the match condition.
- Match: ex_rd_in equals rs1 when the instruction reads rs1, or rs2 when it reads rs2.
- rs2 is read only by OP, BRANCH and STORE.
- rs1 is read by everything except LUI, AUIPC and JAL.
REQ-012 hazard_stall_out SHALL be forced to 0 while stall_in or flush_in is high.
REQ-013 When valid_in=0 the stage SHALL load a bubble (valid_out<=0).
REQ-014 Immediate formats I/S/B/U/J SHALL be sign-extended from instr_in[31].
- Shift-immediates (SLLI, SRLI, SRAI) SHALL output imm_out = zero-extended instr_in[24:20].
REQ-015 Per-class decode SHALL be:
- LUI: ALU pass-src2, imm U.
- AUIPC: ADD with src1=PC, imm U.
- Loads and stores: ADD reg+imm, with mem width/unsigned from funct3.
- Branches: SUB/SLT/SLTU per funct3; branch_negate_out = funct3[0].
- JAL, JALR: rd_write_out=1.
- OP-IMM and OP: ALU fields as for RV32I.
REQ-016 rd_write_out SHALL be 0 for STORE, BRANCH, illegal instructions and rd=0.
REQ-017 illegal_out SHALL be 1 when any of the following holds:
- unknown opcode;
- instr_in[1:0]!=2'b11;
- funct3 reserved for its opcode;
- funct7 not in {0x00, 0x20 where defined, 0x01 when M_EXT=1};
- JALR with funct3!=0.
REQ-018 For an illegal instruction, all side-effect outputs SHALL be 0: rd_write_out, mem_read_out, mem_write_out, branch_out, jal_out, jalr_out and muldiv_out.
REQ-019 A RV32M instruction with M_EXT=0 SHALL be illegal; with M_EXT=1 it SHALL give muldiv_out=1 and rd_write_out=1.
REQ-020 Outputs not meaningful for an instruction (for example imm_out for OP) SHALL be driven 0, never X.

Reset
REQ-021 While reset=1 the stage SHALL take, at the clock edge, the outputs below, and reset SHALL override flush_in and stall_in.
- valid_out, illegal_out, all control flags = 0.
- alu_op_out=0, mem_width_out=0, muldiv_op_out=0.
- pc_out, imm_out = 0; rs1_out, rs2_out, rd_out = 0.
REQ-022 A reset asserted mid-stall SHALL discard the held instruction.

Structure
REQ-023 The shared package SHALL hold the opcode, funct3 and funct7 constants (including FUNCT7_MULDIV=7'h01), the ALU-op and src-select encodings, and the mem-width encodings.
REQ-024 One combinational sub-module, rv32_imm_gen (instr in, format select in, 32-bit imm out), SHALL be instantiated.
REQ-025 The register file SHALL be outside this block.

Verification
REQ-026 ADDI x1,x0,5 (0x00500093), valid_in=1 -> next cycle valid_out=1, alu_src2_out=IMM, imm_out=5, rd_out=1, rd_write_out=1.
REQ-027 SRAI x5,x5,3 (0x4032D293) -> alu_op_out=SRL_SRA, alu_sub_sra_out=1, imm_out=3.
REQ-028 ex_load_in=1, ex_rd_in=2, instr ADD x3,x2,x1 (0x001101B3) -> hazard_stall_out=1 that cycle, valid_out=0 next cycle.
- Then drop ex_load_in -> the instruction issues.
REQ-029 MUL x3,x1,x2 (0x022081B3):
- M_EXT=0 -> illegal_out=1, rd_write_out=0.
- M_EXT=1 -> muldiv_out=1, muldiv_op_out=0.
REQ-030 Hold stall_in=1 for 3 cycles with a valid instruction loaded -> outputs stable.
- Assert flush_in and stall_in together -> valid_out=0 next cycle.
REQ-031 Assert reset during a stall -> every output is 0 on the following cycle.

Source files
------------

// File: rtl/rv32_decode_pipe_pkg.sv
// rtl/rv32_decode_pipe_pkg.sv - shared RV32I/M decode constants, encodings and control bundle
// Contents: opcode/funct3/funct7 constants, ALU-op and source-select codes,
// memory-width codes, immediate-format select enum, registered control struct.
package rv32_decode_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_JALR    = 3'd0;
  localparam logic [2:0] F3_BEQ     = 3'd0;
  localparam logic [2:0] F3_BNE     = 3'd1;
  localparam logic [2:0] F3_BLT     = 3'd4;
  localparam logic [2:0] F3_BGE     = 3'd5;
  localparam logic [2:0] F3_BLTU    = 3'd6;
  localparam logic [2:0] F3_BGEU    = 3'd7;

  localparam logic [6:0] FUNCT7_BASE   = 7'h00;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  // Codes 0..7 coincide with the OP/OP-IMM funct3 values.
  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SLL     = 4'd1;
  localparam logic [3:0] ALU_SLT     = 4'd2;
  localparam logic [3:0] ALU_SLTU    = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SRL_SRA = 4'd5;
  localparam logic [3:0] ALU_OR      = 4'd6;
  localparam logic [3:0] ALU_AND     = 4'd7;
  localparam logic [3:0] ALU_PASS    = 4'd8;

  localparam logic SRC1_RS1 = 1'b0;
  localparam logic SRC1_PC  = 1'b1;
  localparam logic SRC2_RS2 = 1'b0;
  localparam logic SRC2_IMM = 1'b1;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_fmt_e;

  typedef struct packed {
    logic       illegal;
    logic [3:0] alu_op;
    logic       alu_sub_sra;
    logic       alu_src1;
    logic       alu_src2;
    logic       rd_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_width;
    logic       mem_unsigned;
    logic       branch;
    logic       branch_negate;
    logic       jal;
    logic       jalr;
    logic       muldiv;
    logic [2:0] muldiv_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

endpackage

// File: rtl/rv32_decode_pipe_imm_gen.sv
// rtl/rv32_decode_pipe_imm_gen.sv - combinational RV32 immediate generator
// Ports: instr (32-bit instruction word), fmt (immediate format select),
// imm (32-bit immediate; sign-extended from instr[31], shamt zero-extended).
module rv32_imm_gen
  import rv32_decode_pipe_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  logic [31:0] sx;
  logic        unused_opcode_bits;

  assign sx = {32{instr[31]}};
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm = 32'd0;
    case (fmt)
      IMM_I:     imm = {sx[31:12], instr[31:20]};
      IMM_S:     imm = {sx[31:12], instr[31:25], instr[11:7]};
      IMM_B:     imm = {sx[31:13], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm = {instr[31:12], 12'd0};
      IMM_J:     imm = {sx[31:21], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: imm = {27'd0, instr[24:20]};
      default:   imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_pipe.sv
// rtl/rv32_decode_pipe.sv - single-cycle registered RV32I(+M) decode stage with load-use hazard detect
// Ports: clk/reset (sync active-high), valid_in/stall_in/flush_in handshake,
// pc_in/instr_in fetch data, ex_load_in/ex_rd_in load in execute,
// hazard_stall_out and rs1/rs2_addr_out (combinational), registered decode outputs.
module rv32_decode_pipe
  import rv32_decode_pipe_pkg::*;
#(
  parameter int unsigned M_EXT         = 0,
  parameter int unsigned ILLEGAL_VALID = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        ex_load_in,
  input  logic [4:0]  ex_rd_in,
  output logic        hazard_stall_out,
  output logic [4:0]  rs1_addr_out,
  output logic [4:0]  rs2_addr_out,
  output logic        valid_out,
  output logic        illegal_out,
  output logic [3:0]  alu_op_out,
  output logic        alu_sub_sra_out,
  output logic        alu_src1_out,
  output logic        alu_src2_out,
  output logic        rd_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [1:0]  mem_width_out,
  output logic        mem_unsigned_out,
  output logic        branch_out,
  output logic        branch_negate_out,
  output logic        jal_out,
  output logic        jalr_out,
  output logic        muldiv_out,
  output logic [2:0]  muldiv_op_out,
  output logic [31:0] pc_out,
  output logic [31:0] imm_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        uses_rs1, uses_rs2, legal, writes_rd;
  imm_fmt_e    fmt;
  ctrl_t       ctrl, ctrl_q;
  logic [31:0] imm, imm_q, pc_q;
  logic        valid_q;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  assign rs1_addr_out = instr_in[19:15];
  assign rs2_addr_out = instr_in[24:20];

  // Register-read usage depends only on the opcode, so unknown opcodes still
  // count as reading rs1 for hazard purposes.
  assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2 = opcode inside {OPC_OP, OPC_BRANCH, OPC_STORE};

  assign hazard_stall_out = valid_in && ex_load_in && (ex_rd_in != 5'd0) && !stall_in && !flush_in &&
                            ((uses_rs1 && ex_rd_in == rs1_addr_out) || (uses_rs2 && ex_rd_in == rs2_addr_out));

  rv32_imm_gen u_imm_gen (.instr(instr_in), .fmt(fmt), .imm(imm));

  always_comb begin
    ctrl      = '0;
    fmt       = IMM_NONE;
    legal     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1; fmt = IMM_U;
        ctrl.alu_op = ALU_PASS; ctrl.alu_src2 = SRC2_IMM;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1; fmt = IMM_U;
        ctrl.alu_src1 = SRC1_PC; ctrl.alu_src2 = SRC2_IMM;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; fmt = IMM_J; ctrl.jal = 1'b1;
        ctrl.alu_src1 = SRC1_PC; ctrl.alu_src2 = SRC2_IMM;
      end
      OPC_JALR: begin
        legal = (funct3 == F3_JALR); writes_rd = 1'b1; fmt = IMM_I;
        ctrl.jalr = 1'b1; ctrl.alu_src2 = SRC2_IMM;
      end
      OPC_BRANCH: begin
        legal = 1'b1; fmt = IMM_B; ctrl.branch = 1'b1;
        ctrl.branch_negate = funct3[0];
        case (funct3)
          F3_BEQ, F3_BNE:   ctrl.alu_sub_sra = 1'b1;
          F3_BLT, F3_BGE:   ctrl.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: ctrl.alu_op = ALU_SLTU;
          default:          legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = (funct3 != 3'd3) && (funct3 < 3'd6); writes_rd = 1'b1; fmt = IMM_I;
        ctrl.mem_read = 1'b1; ctrl.mem_width = funct3[1:0];
        ctrl.mem_unsigned = funct3[2]; ctrl.alu_src2 = SRC2_IMM;
      end
      OPC_STORE: begin
        legal = (funct3 <= 3'd2); fmt = IMM_S;
        ctrl.mem_write = 1'b1; ctrl.mem_width = funct3[1:0]; ctrl.alu_src2 = SRC2_IMM;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1; ctrl.alu_op = {1'b0, funct3}; ctrl.alu_src2 = SRC2_IMM;
        if (funct3 == F3_SLL) begin
          legal = (funct7 == FUNCT7_BASE); fmt = IMM_SHAMT;
        end else if (funct3 == F3_SRL_SRA) begin
          legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT); fmt = IMM_SHAMT;
          ctrl.alu_sub_sra = (funct7 == FUNCT7_ALT);
        end else begin
          legal = 1'b1; fmt = IMM_I;
        end
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        if (funct7 == FUNCT7_MULDIV) begin
          legal = (M_EXT != 0); ctrl.muldiv = 1'b1; ctrl.muldiv_op = funct3;
        end else begin
          legal = (funct7 == FUNCT7_BASE) ||
                  (funct7 == FUNCT7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
          ctrl.alu_op = {1'b0, funct3}; ctrl.alu_sub_sra = (funct7 == FUNCT7_ALT);
        end
      end
      default: legal = 1'b0;
    endcase
    if (instr_in[1:0] != 2'b11) legal = 1'b0;
    ctrl.rs1 = uses_rs1 ? rs1_addr_out : 5'd0;
    ctrl.rs2 = uses_rs2 ? rs2_addr_out : 5'd0;
    if (writes_rd) begin
      ctrl.rd       = instr_in[11:7];
      ctrl.rd_write = (instr_in[11:7] != 5'd0);
    end
    // Illegal words carry only the flag (and the PC, captured separately).
    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      fmt          = IMM_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      valid_q <= 1'b0; ctrl_q <= '0; pc_q <= 32'd0; imm_q <= 32'd0;
    end else if (stall_in) begin
      valid_q <= valid_q; ctrl_q <= ctrl_q; pc_q <= pc_q; imm_q <= imm_q;
    end else if (hazard_stall_out || !valid_in || (ctrl.illegal && ILLEGAL_VALID == 0)) begin
      // Bubbles are all-zero so nothing stale reaches execute.
      valid_q <= 1'b0; ctrl_q <= '0; pc_q <= 32'd0; imm_q <= 32'd0;
    end else begin
      valid_q <= 1'b1; ctrl_q <= ctrl; pc_q <= pc_in; imm_q <= imm;
    end
  end

  assign valid_out         = valid_q;
  assign illegal_out       = ctrl_q.illegal;
  assign alu_op_out        = ctrl_q.alu_op;
  assign alu_sub_sra_out   = ctrl_q.alu_sub_sra;
  assign alu_src1_out      = ctrl_q.alu_src1;
  assign alu_src2_out      = ctrl_q.alu_src2;
  assign rd_write_out      = ctrl_q.rd_write;
  assign mem_read_out      = ctrl_q.mem_read;
  assign mem_write_out     = ctrl_q.mem_write;
  assign mem_width_out     = ctrl_q.mem_width;
  assign mem_unsigned_out  = ctrl_q.mem_unsigned;
  assign branch_out        = ctrl_q.branch;
  assign branch_negate_out = ctrl_q.branch_negate;
  assign jal_out           = ctrl_q.jal;
  assign jalr_out          = ctrl_q.jalr;
  assign muldiv_out        = ctrl_q.muldiv;
  assign muldiv_op_out     = ctrl_q.muldiv_op;
  assign pc_out            = pc_q;
  assign imm_out           = imm_q;
  assign rs1_out           = ctrl_q.rs1;
  assign rs2_out           = ctrl_q.rs2;
  assign rd_out            = ctrl_q.rd;

endmodule
